// File: rtl/i2c_pkg.sv
// Shared I2C definitions: target FSM states, R/W bit and ACK/NACK levels.
package i2c_pkg;

  typedef enum logic [3:0] {
    IDLE,
    ADDR,
    ADDR_ACK,
    PTR,
    PTR_ACK,
    WDATA,
    WDATA_ACK,
    RDATA,
    RACK,
    WAIT_STOP
  } i2c_tgt_state_t;

  localparam logic I2C_RW_WRITE = 1'b0;
  localparam logic I2C_RW_READ  = 1'b1;
  localparam logic ACK          = 1'b0;
  localparam logic NACK         = 1'b1;

endpackage

// File: rtl/i2c_target_mem_if.sv
// I2C pin bundle for the target: raw SCL/SDA in, open-drain SDA pull-down out.
interface i2c_target_mem_if;
  logic scl_i;
  logic sda_i;
  logic sda_oe;

  modport master (output scl_i, output sda_i, input sda_oe);
  modport slave  (input scl_i, input sda_i, output sda_oe);
endinterface

// File: rtl/i2c_bus_sync.sv
// SCL/SDA synchronizer with edge, START and STOP detection.
// Outputs are valid 2 clk after a pin change; no flow control.
module i2c_bus_sync (
  input  logic clk,
  input  logic reset,
  input  logic scl_in,
  input  logic sda_in,
  output logic scl,
  output logic sda,
  output logic scl_rise,
  output logic scl_fall,
  output logic start_det,
  output logic stop_det
);

  logic [1:0] scl_ff;
  logic [1:0] sda_ff;
  logic       scl_prev;
  logic       sda_prev;

  // Idle bus is high, so reset to 1 to avoid phantom edges after reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      scl_ff   <= 2'b11;
      sda_ff   <= 2'b11;
      scl_prev <= 1'b1;
      sda_prev <= 1'b1;
    end else begin
      scl_ff   <= {scl_ff[0], scl_in};
      sda_ff   <= {sda_ff[0], sda_in};
      scl_prev <= scl_ff[1];
      sda_prev <= sda_ff[1];
    end
  end

  assign scl       = scl_ff[1];
  assign sda       = sda_ff[1];
  assign scl_rise  = scl & ~scl_prev;
  assign scl_fall  = ~scl & scl_prev;
  assign start_det = scl & scl_prev & sda_prev & ~sda;
  assign stop_det  = scl & scl_prev & ~sda_prev & sda;

endmodule

// File: rtl/i2c_target_mem.sv
// I2C target with a byte-addressed register file and auto-incrementing pointer.
// SCL pin edge to sda_oe change is 3 clk; the master stretches nothing, it must hold SCL low >= 4 clk.
module i2c_target_mem
  import i2c_pkg::*;
#(
  parameter logic [6:0] DEV_ADDR  = 7'h2A,
  parameter int         MEM_DEPTH = 64,
  parameter int         PTR_W     = 6
) (
  input  logic               clk,
  input  logic               reset,
  i2c_target_mem_if.slave    bus,
  output logic               busy,
  output logic               wr_strobe,
  output logic [PTR_W-1:0]   wr_addr,
  output logic [7:0]         wr_data
);

  localparam logic [PTR_W-1:0] PTR_ONE = {{(PTR_W-1){1'b0}}, 1'b1};

  logic sda_s, scl_unused, scl_rise, scl_fall, start_det, stop_det;

  i2c_bus_sync u_sync (
    .clk       (clk),
    .reset     (reset),
    .scl_in    (bus.scl_i),
    .sda_in    (bus.sda_i),
    .scl       (scl_unused),
    .sda       (sda_s),
    .scl_rise  (scl_rise),
    .scl_fall  (scl_fall),
    .start_det (start_det),
    .stop_det  (stop_det)
  );

  i2c_tgt_state_t    state_q, state_d;
  logic [2:0]        bit_cnt_q, bit_cnt_d;
  logic              byte_done_q, byte_done_d;
  logic [7:0]        shreg_q, shreg_d;
  logic              rw_q, rw_d;
  logic [PTR_W-1:0]  ptr_q, ptr_d, ptr_inc;
  logic              oe_q, oe_d;
  logic              busy_q, busy_d;
  logic              strobe_d, mem_we, phase_end;
  logic [PTR_W-1:0]  waddr_d;
  logic [7:0]        wdata_d;
  logic [7:0]        mem [MEM_DEPTH];
  logic [7:0]        cur_byte, next_byte;

  assign ptr_inc   = ptr_q + PTR_ONE;
  assign cur_byte  = mem[ptr_q];
  assign next_byte = mem[ptr_inc];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      bit_cnt_q   <= '0;
      byte_done_q <= 1'b0;
      shreg_q     <= '0;
      rw_q        <= I2C_RW_WRITE;
      ptr_q       <= '0;
      oe_q        <= 1'b0;
      busy_q      <= 1'b0;
      wr_strobe   <= 1'b0;
      wr_addr     <= '0;
      wr_data     <= '0;
      for (int i = 0; i < MEM_DEPTH; i++) mem[i] <= '0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      byte_done_q <= byte_done_d;
      shreg_q     <= shreg_d;
      rw_q        <= rw_d;
      ptr_q       <= ptr_d;
      oe_q        <= oe_d;
      busy_q      <= busy_d;
      wr_strobe   <= strobe_d;
      wr_addr     <= waddr_d;
      wr_data     <= wdata_d;
      if (mem_we) mem[ptr_q] <= shreg_q;
    end
  end

  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    byte_done_d = byte_done_q;
    shreg_d     = shreg_q;
    rw_d        = rw_q;
    ptr_d       = ptr_q;
    oe_d        = oe_q;
    busy_d      = busy_q;
    strobe_d    = 1'b0;
    mem_we      = 1'b0;
    waddr_d     = wr_addr;
    wdata_d     = wr_data;
    phase_end   = 1'b0;

    if (start_det) begin
      state_d   = ADDR;
      oe_d      = 1'b0;
      busy_d    = 1'b0;
      phase_end = 1'b1;
    end else if (stop_det) begin
      state_d   = IDLE;
      oe_d      = 1'b0;
      busy_d    = 1'b0;
      phase_end = 1'b1;
    end else if (scl_rise) begin
      // Shift every rise; the counter is cleared whenever a phase ends.
      shreg_d   = {shreg_q[6:0], sda_s};
      bit_cnt_d = bit_cnt_q + 3'd1;
      if (bit_cnt_q == 3'd7) byte_done_d = 1'b1;
    end else if (scl_fall) begin
      case (state_q)
        ADDR: if (byte_done_q) begin
          phase_end = 1'b1;
          if (shreg_q[7:1] == DEV_ADDR) begin
            state_d = ADDR_ACK;
            oe_d    = 1'b1;
            busy_d  = 1'b1;
            rw_d    = shreg_q[0];
          end else begin
            state_d = WAIT_STOP;
            oe_d    = 1'b0;
          end
        end
        ADDR_ACK: begin
          phase_end = 1'b1;
          if (rw_q == I2C_RW_READ) begin
            state_d = RDATA;
            oe_d    = ~cur_byte[7];
          end else begin
            state_d = PTR;
            oe_d    = 1'b0;
          end
        end
        PTR: if (byte_done_q) begin
          phase_end = 1'b1;
          ptr_d     = shreg_q[PTR_W-1:0];
          oe_d      = 1'b1;
          state_d   = PTR_ACK;
        end
        WDATA: if (byte_done_q) begin
          phase_end = 1'b1;
          mem_we    = 1'b1;
          strobe_d  = 1'b1;
          waddr_d   = ptr_q;
          wdata_d   = shreg_q;
          ptr_d     = ptr_inc;
          oe_d      = 1'b1;
          state_d   = WDATA_ACK;
        end
        PTR_ACK, WDATA_ACK: begin
          phase_end = 1'b1;
          oe_d      = 1'b0;
          state_d   = WDATA;
        end
        RDATA: begin
          if (byte_done_q) begin
            phase_end = 1'b1;
            oe_d      = 1'b0;
            state_d   = RACK;
          end else begin
            oe_d = ~cur_byte[~bit_cnt_q];
          end
        end
        RACK: begin
          phase_end = 1'b1;
          if (shreg_q[0] == ACK) begin
            ptr_d   = ptr_inc;
            oe_d    = ~next_byte[7];
            state_d = RDATA;
          end else begin
            oe_d    = 1'b0;
            state_d = WAIT_STOP;
          end
        end
        default: ;
      endcase
    end

    if (phase_end) begin
      bit_cnt_d   = '0;
      byte_done_d = 1'b0;
    end
  end

  assign bus.sda_oe = oe_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_i2c_target_mem.sv
// Directed I2C bus-master bench for i2c_target_mem with write/read scoreboards.
module tb_i2c_target_mem;
  import i2c_pkg::*;

  localparam int H = 8;

  logic clk = 1'b0;
  logic reset;
  logic scl_m, sda_m;
  logic busy, wr_strobe;
  logic [5:0] wr_addr;
  logic [7:0] wr_data;

  int vectors = 0;
  int miscompares = 0;
  int oe_cnt = 0;
  int st_cnt = 0;
  logic [13:0] wr_q[$];
  logic [7:0]  rd_q[$];

  i2c_target_mem_if bus ();

  assign bus.scl_i = scl_m;
  assign bus.sda_i = sda_m & ~bus.sda_oe;

  i2c_target_mem #(.DEV_ADDR(7'h2A), .MEM_DEPTH(64), .PTR_W(6)) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .busy      (busy),
    .wr_strobe (wr_strobe),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(posedge clk) begin
    if (bus.sda_oe) oe_cnt++;
    if (wr_strobe) st_cnt++;
  end

  always @(negedge clk) begin
    if (!reset && wr_strobe) begin
      if (wr_q.size() == 0) begin
        chk("wr_unexpected", {26'd0, wr_addr}, 32'hFFFF_FFFF);
      end else begin
        logic [13:0] e;
        e = wr_q.pop_front();
        chk("wr_addr", {26'd0, wr_addr}, {26'd0, e[13:8]});
        chk("wr_data", {24'd0, wr_data}, {24'd0, e[7:0]});
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: bench did not complete");
    $fatal(1, "watchdog");
  end

  task automatic wait_h();
    repeat (H) @(posedge clk);
    #1;
  endtask

  task automatic do_start();
    if (scl_m == 1'b0) begin
      sda_m = 1'b1; wait_h();
      scl_m = 1'b1; wait_h();
    end
    sda_m = 1'b0; wait_h();
    scl_m = 1'b0; wait_h();
  endtask

  task automatic do_bit(input logic b, output logic s);
    sda_m = b; wait_h();
    scl_m = 1'b1; wait_h();
    s = bus.sda_i;
    scl_m = 1'b0; wait_h();
  endtask

  task automatic do_stop_check();
    sda_m = 1'b0; wait_h();
    scl_m = 1'b1; wait_h();
    sda_m = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("busy_after_stop", {31'd0, busy}, 32'd0);
    wait_h();
  endtask

  task automatic send_byte(input logic [7:0] b, output logic ack);
    logic s;
    for (int i = 7; i >= 0; i--) do_bit(b[i], s);
    do_bit(1'b1, ack);
  endtask

  task automatic recv_byte(output logic [7:0] d, input logic mack);
    logic s;
    for (int i = 7; i >= 0; i--) begin
      do_bit(1'b1, s);
      d[i] = s;
    end
    do_bit(mack, s);
  endtask

  task automatic send_ack(input string tag, input logic [7:0] b);
    logic a;
    send_byte(b, a);
    chk(tag, {31'd0, a}, {31'd0, ACK});
  endtask

  task automatic rd_seq(input logic [7:0] ptr, input int n);
    logic [7:0] d, e;
    do_start();
    send_ack("rd_addr_w_ack", 8'h54);
    send_ack("rd_ptr_ack", ptr);
    do_start();
    send_ack("rd_addr_r_ack", 8'h55);
    for (int i = 0; i < n; i++) begin
      recv_byte(d, (i == n - 1) ? NACK : ACK);
      e = rd_q.pop_front();
      chk("rd_data", {24'd0, d}, {24'd0, e});
    end
    chk("oe_after_nack", {31'd0, bus.sda_oe}, 32'd0);
    do_stop_check();
  endtask

  initial begin
    int oe0, st0;
    logic a, s;
    logic [7:0] b;
    reset = 1'b1; scl_m = 1'b1; sda_m = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_sda_oe", {31'd0, bus.sda_oe}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_wr_strobe", {31'd0, wr_strobe}, 32'd0);
    chk("rst_wr_addr", {26'd0, wr_addr}, 32'd0);
    chk("rst_wr_data", {24'd0, wr_data}, 32'd0);
    reset = 1'b0;
    wait_h();

    // Write burst at pointer 5
    do_start();
    send_ack("w_addr_ack", 8'h54);
    chk("busy_matched", {31'd0, busy}, 32'd1);
    send_ack("w_ptr_ack", 8'h05);
    wr_q.push_back({6'd5, 8'hA5});
    send_ack("w_d0_ack", 8'hA5);
    wr_q.push_back({6'd6, 8'h3C});
    send_ack("w_d1_ack", 8'h3C);
    do_stop_check();

    // Read back through a repeated START
    rd_q.push_back(8'hA5);
    rd_q.push_back(8'h3C);
    rd_seq(8'h05, 2);

    // Address mismatch
    oe0 = oe_cnt; st0 = st_cnt;
    do_start();
    send_byte(8'h56, a);
    chk("mm_nack", {31'd0, a}, {31'd0, NACK});
    send_byte(8'h00, a);
    chk("mm_oe_cycles", oe_cnt - oe0, 32'd0);
    chk("mm_strobes", st_cnt - st0, 32'd0);
    chk("mm_busy", {31'd0, busy}, 32'd0);
    do_stop_check();

    // Pointer wrap 63 -> 0
    do_start();
    send_ack("wrap_addr_ack", 8'h54);
    send_ack("wrap_ptr_ack", 8'h3F);
    wr_q.push_back({6'd63, 8'h11});
    send_ack("wrap_d0_ack", 8'h11);
    wr_q.push_back({6'd0, 8'h22});
    send_ack("wrap_d1_ack", 8'h22);
    do_stop_check();
    rd_q.push_back(8'h11);
    rd_q.push_back(8'h22);
    rd_seq(8'h3F, 2);

    // Pointer upper bits ignored
    do_start();
    send_ack("hi_addr_ack", 8'h54);
    send_ack("hi_ptr_ack", 8'hC7);
    wr_q.push_back({6'd7, 8'h99});
    send_ack("hi_d0_ack", 8'h99);
    do_stop_check();

    // STOP after a partial data byte
    st0 = st_cnt;
    do_start();
    send_ack("ab_addr_ack", 8'h54);
    send_ack("ab_ptr_ack", 8'h10);
    do_bit(1'b1, s); do_bit(1'b0, s); do_bit(1'b1, s); do_bit(1'b0, s);
    do_stop_check();
    chk("ab_strobes", st_cnt - st0, 32'd0);
    rd_q.push_back(8'h00);
    rd_seq(8'h10, 1);

    // Reset asserted while the target is ACKing the address
    do_start();
    b = 8'h54;
    for (int i = 7; i >= 0; i--) do_bit(b[i], s);
    sda_m = 1'b1;
    wait_h();
    chk("ack_before_rst", {31'd0, bus.sda_oe}, 32'd1);
    reset = 1'b1;
    #1;
    chk("oe_async_rst", {31'd0, bus.sda_oe}, 32'd0);
    chk("busy_async_rst", {31'd0, busy}, 32'd0);
    scl_m = 1'b1; sda_m = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    reset = 1'b0;
    wait_h();
    rd_q.push_back(8'h00);
    rd_q.push_back(8'h00);
    rd_seq(8'h05, 2);

    chk("wr_q_drained", wr_q.size(), 32'd0);
    chk("rd_q_drained", rd_q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/i2c_target_mem.md
Name: i2c_target_mem

Overview:
- I2C target (slave) responder paired with the team's I2C master. Holds a small byte-addressed register memory.
- Synchronously oversamples SCL/SDA on the system clock. Detects START/STOP, matches a 7-bit device address, ACKs, and takes a memory pointer byte.
- After the pointer, it either stores write bytes or returns read bytes, with pointer auto-increment in both cases.
- Sits on the I2C bus opposite the master; drives SDA open-drain only.

Parameters:
- DEV_ADDR, 7'h2A, 7-bit device address matched after START.
- MEM_DEPTH, 64, number of 8-bit registers; power of two.
- PTR_W, 6, pointer width, equal to log2(MEM_DEPTH).

Ports:
- clk  input  1  system clock. One clock, all logic on its rising edge.
- reset  input  1  asynchronous, active-high reset.
- scl_i  input  1  raw SCL from the bus. Asynchronous.
- sda_i  input  1  raw SDA from the bus. Asynchronous.
- sda_oe  output  1  1 pulls SDA low; 0 releases it. Never drives high.
- busy  output  1  high from an address-matched START until the following STOP.
- wr_strobe  output  1  one-cycle pulse when a data byte is committed to memory.
- wr_addr  output  PTR_W  address of the committed byte. Valid with wr_strobe.
- wr_data  output  8  value of the committed byte. Valid with wr_strobe.

Behaviour:
- Reset values: sda_oe=0, busy=0, wr_strobe=0, wr_addr=0, wr_data=0, pointer=0, memory all 0x00, state=IDLE, bit counter=0.
- Input conditioning:
  - 2-flop synchronizer on scl_i and sda_i (reset value 1), followed by a previous-value flop.
  - scl_rise/scl_fall are single-cycle pulses.
  - START = synced SDA 1->0 while synced SCL=1. STOP = synced SDA 0->1 while synced SCL=1.
- Timing:
  - SDA is sampled on scl_rise.
  - sda_oe changes only on scl_fall, registered.
  - SCL pin edge to sda_oe change is 3 clk. The bus must hold SCL low for at least 4 clk.
- States: IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RACK, WAIT_STOP.
- Shift phase: ADDR, PTR, WDATA and RDATA each move 8 bits MSB-first. The bit counter counts 0..7; after the 8th scl_rise the next scl_fall enters the ACK phase.
- ADDR:
  - Byte is {addr[6:0], rw}.
  - If addr==DEV_ADDR: on scl_fall assert sda_oe (ACK) and go to ADDR_ACK; set busy.
  - Otherwise go to WAIT_STOP with sda_oe=0.
- ADDR_ACK, on the next scl_fall:
  - rw=0: release SDA, go to PTR.
  - rw=1: go to RDATA and drive ~mem[ptr][7].
- PTR: the received byte loads the pointer from its low PTR_W bits; upper bits are ignored. ACK, then PTR_ACK, then WDATA.
- WDATA:
  - The received byte writes mem[ptr], pulses wr_strobe, presents wr_addr=ptr and wr_data=byte.
  - Then ACK and increment the pointer.
  - Commit happens on the scl_fall that asserts ACK.
- RDATA:
  - On each scl_fall drive sda_oe=~bit of mem[ptr], MSB first.
  - After bit 0, the next scl_fall releases SDA and enters RACK.
- RACK: sample SDA on scl_rise.
  - 0 (master ACK): increment ptr; on scl_fall drive the MSB of the new byte and re-enter RDATA.
  - 1 (NACK): go to WAIT_STOP, SDA released.
- Pointer arithmetic: increments modulo MEM_DEPTH, so 63 wraps to 0.
- START anywhere, including a repeated START mid-byte or mid-ACK: release sda_oe, clear the bit counter, enter ADDR. The pointer is retained; busy clears until the next address match.
- STOP anywhere: release sda_oe, busy=0, enter IDLE. A partial write byte is discarded.
- WAIT_STOP: ignores SCL activity and stays released until START or STOP.
- START and scl_fall in the same cycle: START wins.
- Asynchronous reset mid-transfer: SDA released immediately, all state returns to reset values.

Decomposition:
- Package i2c_pkg:
  - state enum typedef (i2c_tgt_state_t).
  - I2C_RW_WRITE=0 and I2C_RW_READ=1.
  - ACK=0 and NACK=1 constants.
  - Shared with the master.
- Sub-module i2c_bus_sync: 2-flop synchronizers plus edge/START/STOP detection. Outputs scl, sda, scl_rise, scl_fall, start_det, stop_det.
- Memory is a reg array inside i2c_target_mem.

Test Plan:
- Write burst: START, 0x54 (0x2A,W), ptr 0x05, data 0xA5, 0x3C, STOP.
  - Required: ACK on all 4 bytes.
  - wr_strobe twice: (5,0xA5), then (6,0x3C).
  - busy falls within 3 clk of STOP.
- Read with repeated START: write ptr 0x05, then Sr, 0x55 (0x2A,R), read 2 bytes with ACK then NACK, STOP.
  - Required: SDA carries 0xA5 then 0x3C; after the NACK sda_oe=0.
- Address mismatch: START, 0x56 (0x2B,W), 0x00.
  - Required: sda_oe never asserted, no wr_strobe, busy=0.
- Wrap: write ptr 0x3F, data 0x11, 0x22.
  - Required: commits at 63 then 0.
  - A subsequent read from ptr 0x3F returns 0x11, 0x22.
- Abort: STOP after 4 data bits of a write byte; reset asserted mid-ACK in a second transfer.
  - Required: no commit from the partial byte.
  - sda_oe=0 asynchronously on reset; memory reads back 0x00.
- Pointer high bits: ptr byte 0xC7.
  - Required: pointer=7; write 0x99 commits wr_addr=7.
